camera_word_packer: RTL and testbench

- Sits directly downstream of the camera reader stage in the pixclk domain.
- Consumes its per-pixel stream (pix_valid, 8-bit pixel, row, col) and packs 4 horizontally adjacent pixels into 32-bit words.
- Each word carries a byte-enable, a linear word address and a start-of-frame flag, buffered in a small FIFO behind a valid/ready interface.
- Feeds the frame-buffer writer / CDC stage.

---
 rtl/camera_word_packer_pkg.sv | 28 ++
 rtl/camera_word_packer_if.sv | 21 ++
 rtl/camera_word_fifo.sv | 53 +++++
 rtl/camera_word_packer.sv | 143 ++++++++++++++
 tb/tb_camera_word_packer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_word_packer_pkg.sv
// Shared types for the camera word packer: pixel/coordinate types, packed FIFO word,
// accumulator state encoding and word-geometry helper.
package camera_pkg;

  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned ADDR_W_MAX   = 32;

  typedef logic [7:0]  pix_t;
  typedef logic [15:0] coord_t;

  // addr is carried at full width; the top truncates it to its ADDR_W on output
  typedef struct packed {
    logic [31:0]           data;
    logic [3:0]            be;
    logic [ADDR_W_MAX-1:0] addr;
    logic                  sof;
  } packed_word_t;

  typedef enum logic {
    ACC_EMPTY,
    ACC_FILLING
  } acc_state_e;

  function automatic int unsigned words_per_row(input int unsigned width);
    return (width + PIX_PER_WORD - 1) / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/camera_word_packer_if.sv
// Packed-word valid/ready bus between the packer (master) and the frame-buffer writer (slave).
interface camera_word_packer_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              word_valid_o;
  logic              word_ready_i;
  logic [31:0]       word_o;
  logic [3:0]        word_be_o;
  logic [ADDR_W-1:0] word_addr_o;
  logic              word_sof_o;

  modport master (
    output word_valid_o, word_o, word_be_o, word_addr_o, word_sof_o,
    input  word_ready_i
  );

  modport slave (
    input  word_valid_o, word_o, word_be_o, word_addr_o, word_sof_o,
    output word_ready_i
  );
endinterface

// File: rtl/camera_word_fifo.sv
// First-word-fall-through sync FIFO of packed words; a push while full is accepted
// only when a pop happens in the same cycle.
module camera_word_fifo
  import camera_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  packed_word_t i_din,
  input  logic         i_pop,
  output packed_word_t o_dout,
  output logic         o_valid,
  output logic         o_full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_count;
  packed_word_t     r_mem [DEPTH];

  logic w_pop;
  logic w_push_ok;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
  assign w_pop     = i_pop && o_valid;
  assign w_push_ok = i_push && (!o_full || w_pop);
  assign o_dout    = r_mem[r_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/camera_word_packer.sv
// Packs 4 adjacent pixels into 32-bit words with byte enables, word address and SOF.
// Optional CAMERA_WORD_PACKER_STATS_EN adds pushed/dropped word counters.
module camera_word_packer
  import camera_pkg::*;
#(
  parameter int unsigned ACTIVE_REGION_WIDTH  = 320,
  parameter int unsigned ACTIVE_REGION_HEIGHT = 240,
  parameter int unsigned ADDR_W               = 15,
  parameter int unsigned FIFO_DEPTH           = 8
) (
  input  logic                pixclk_i,
  input  logic                reset,
  input  logic                pix_valid_i,
  input  pix_t                pix_i,
  input  coord_t              row_i,
  input  coord_t              col_i,
  camera_word_packer_if.master wr,
  output logic                overflow_o,
  output logic                seq_err_o,
  input  logic                clear_err_i
`ifdef CAMERA_WORD_PACKER_STATS_EN
  ,
  output logic [31:0]         words_pushed_o,
  output logic [31:0]         words_dropped_o
`endif
);
  localparam int unsigned WPR = words_per_row(ACTIVE_REGION_WIDTH);

  acc_state_e   r_state, w_state_nxt;
  logic [31:0]  r_data;
  logic [3:0]   r_be;
  coord_t       r_row;
  logic [13:0]  r_wcol;
  logic         r_sof;
  logic         r_seq_err, r_overflow;

  logic [1:0]   w_lane;
  logic [13:0]  w_wcol;
  logic         w_in_range, w_accept, w_same, w_stale, w_dup, w_terminal, w_push;
  logic         w_pop, w_full, w_fifo_valid, w_overflow, w_seq_set;
  packed_word_t w_word, w_head;

  assign w_lane     = col_i[1:0];
  assign w_wcol     = col_i[15:2];
  assign w_in_range = (32'(row_i) < ACTIVE_REGION_HEIGHT) && (32'(col_i) < ACTIVE_REGION_WIDTH);
  assign w_accept   = pix_valid_i && w_in_range;
  assign w_same     = (r_state == ACC_FILLING) && (r_row == row_i) && (r_wcol == w_wcol);
  assign w_stale    = w_accept && (r_state == ACC_FILLING) && !w_same;
  assign w_dup      = w_accept && w_same && r_be[w_lane];
  assign w_terminal = (w_lane == 2'd3) || (32'(col_i) == ACTIVE_REGION_WIDTH - 1);
  assign w_push     = w_accept && w_terminal;

  // Merge the incoming byte onto the accumulator (or onto nothing for a fresh word);
  // the same value feeds the FIFO on the terminal pixel and the registers otherwise.
  always_comb begin
    w_word.data = w_same ? r_data : '0;
    w_word.be   = w_same ? r_be : '0;
    w_word.sof  = w_same && r_sof;
    w_word.addr = 32'(row_i) * 32'(WPR) + 32'(w_wcol);
    w_word.data[{w_lane, 3'b000} +: 8] = pix_i;
    w_word.be[w_lane] = 1'b1;
    if (row_i == '0 && col_i == '0) w_word.sof = 1'b1;
  end

  always_ff @(posedge pixclk_i or posedge reset) begin
    if (reset) r_state <= ACC_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = w_terminal ? ACC_EMPTY : ACC_FILLING;
  end

  always_ff @(posedge pixclk_i or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_be   <= '0;
      r_row  <= '0;
      r_wcol <= '0;
      r_sof  <= 1'b0;
    end else if (w_accept) begin
      r_data <= w_word.data;
      r_be   <= w_word.be;
      r_row  <= row_i;
      r_wcol <= w_wcol;
      r_sof  <= w_word.sof;
    end
  end

  camera_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (pixclk_i),
    .rst    (reset),
    .i_push (w_push),
    .i_din  (w_word),
    .i_pop  (w_pop),
    .o_dout (w_head),
    .o_valid(w_fifo_valid),
    .o_full (w_full)
  );

  assign w_pop      = w_fifo_valid && wr.word_ready_i;
  assign w_overflow = w_push && w_full && !w_pop;
  assign w_seq_set  = (pix_valid_i && !w_in_range) || w_stale || w_dup;

  always_ff @(posedge pixclk_i or posedge reset) begin
    if (reset) begin
      r_seq_err  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_seq_set)        r_seq_err <= 1'b1;
      else if (clear_err_i) r_seq_err <= 1'b0;
      if (w_overflow)       r_overflow <= 1'b1;
      else if (clear_err_i) r_overflow <= 1'b0;
    end
  end

  assign seq_err_o       = r_seq_err;
  assign overflow_o      = r_overflow;
  assign wr.word_valid_o = w_fifo_valid;
  assign wr.word_o       = w_fifo_valid ? w_head.data : '0;
  assign wr.word_be_o    = w_fifo_valid ? w_head.be : '0;
  assign wr.word_addr_o  = w_fifo_valid ? w_head.addr[ADDR_W-1:0] : '0;
  assign wr.word_sof_o   = w_fifo_valid && w_head.sof;

`ifdef CAMERA_WORD_PACKER_STATS_EN
  logic [31:0] r_pushed, r_dropped;

  always_ff @(posedge pixclk_i or posedge reset) begin
    if (reset) begin
      r_pushed  <= '0;
      r_dropped <= '0;
    end else begin
      if (w_push && !w_overflow) r_pushed <= r_pushed + 1'b1;
      r_dropped <= r_dropped + 32'(w_overflow) + 32'(w_stale);
    end
  end

  assign words_pushed_o  = r_pushed;
  assign words_dropped_o = r_dropped;
`endif

endmodule

// File: tb/tb_camera_word_packer.sv
// Randomized and directed bench for camera_word_packer (WIDTH=10 to exercise the short last word).
module tb_camera_word_packer;
  import camera_pkg::*;

  localparam int unsigned W     = 10;
  localparam int unsigned H     = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned WPR   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv = 1'b0;
  logic [7:0]  pix = '0;
  logic [15:0] row = '0;
  logic [15:0] col = '0;
  logic        clr = 1'b0;
  logic        overflow, seq_err;

  camera_word_packer_if #(.ADDR_W(AW)) wif();

`ifdef CAMERA_WORD_PACKER_STATS_EN
  logic [31:0] words_pushed, words_dropped;
`endif

  camera_word_packer #(
    .ACTIVE_REGION_WIDTH (W),
    .ACTIVE_REGION_HEIGHT(H),
    .ADDR_W              (AW),
    .FIFO_DEPTH          (DEPTH)
  ) dut (
    .pixclk_i   (clk),
    .reset      (rst),
    .pix_valid_i(pv),
    .pix_i      (pix),
    .row_i      (row),
    .col_i      (col),
    .wr         (wif),
    .overflow_o (overflow),
    .seq_err_o  (seq_err),
    .clear_err_i(clr)
`ifdef CAMERA_WORD_PACKER_STATS_EN
    ,
    .words_pushed_o (words_pushed),
    .words_dropped_o(words_dropped)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a word is a linear address plus an array of byte slots;
  // the output buffer is a bounded queue.
  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    int unsigned addr;
    logic        sof;
  } exp_word_t;

  exp_word_t   m_q[$];
  bit          m_acc_valid;
  int unsigned m_acc_key;
  logic [7:0]  m_bytes[4];
  logic [3:0]  m_be;
  bit          m_sof, m_seq, m_ovf;
  int unsigned m_pushed, m_dropped;

  function automatic void acc_clear();
    m_acc_valid = 0;
    m_be        = '0;
    m_sof       = 0;
    for (int i = 0; i < 4; i++) m_bytes[i] = '0;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    acc_clear();
    m_acc_key = 0;
    m_seq = 0;
    m_ovf = 0;
    m_pushed = 0;
    m_dropped = 0;
  endfunction

  function automatic void model_step();
    bit          pop, push, seq_set, ovf_set;
    int unsigned key, lane, pre;
    exp_word_t   w;
    pop = (m_q.size() != 0) && wif.word_ready_i;
    push = 0; seq_set = 0; ovf_set = 0;
    w = '{data: '0, be: '0, addr: 0, sof: 0};
    if (pv) begin
      if (row >= H || col >= W) seq_set = 1;
      else begin
        key  = row * WPR + col / 4;
        lane = col % 4;
        if (m_acc_valid && key != m_acc_key) begin
          seq_set = 1;
          m_dropped++;
          acc_clear();
        end
        if (m_acc_valid && m_be[lane]) seq_set = 1;
        m_bytes[lane] = pix;
        m_be[lane]    = 1'b1;
        if (row == 0 && col == 0) m_sof = 1;
        m_acc_key   = key;
        m_acc_valid = 1;
        if (lane == 3 || col == W - 1) begin
          push   = 1;
          w.data = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          w.be   = m_be;
          w.addr = key;
          w.sof  = m_sof;
          acc_clear();
        end
      end
    end
    pre = m_q.size();
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (pre == DEPTH && !pop) begin
        ovf_set = 1;
        m_dropped++;
      end else begin
        m_q.push_back(w);
        m_pushed++;
      end
    end
    m_seq = seq_set ? 1'b1 : (clr ? 1'b0 : m_seq);
    m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endfunction

  task automatic compare_outputs();
    logic [31:0] mask;
    check("valid", wif.word_valid_o, m_q.size() != 0);
    if (m_q.size() != 0) begin
      for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{m_q[0].be[i]}};
      check("data", wif.word_o & mask, m_q[0].data & mask);
      check("be", wif.word_be_o, m_q[0].be);
      check("addr", wif.word_addr_o, m_q[0].addr);
      check("sof", wif.word_sof_o, m_q[0].sof);
    end
    check("seq_err", seq_err, m_seq);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle();
    pv = 1'b0;
    cycle();
  endtask

  task automatic pixel(input int unsigned r, input int unsigned c, input logic [7:0] p);
    pv  = 1'b1;
    row = 16'(r);
    col = 16'(c);
    pix = p;
    cycle();
    pv  = 1'b0;
  endtask

  int unsigned rr, cc, x;

  initial begin
    model_reset();
    wif.word_ready_i = 1'b1;
    #12;
    check("rst_valid", wif.word_valid_o, 1'b0);
    check("rst_word", wif.word_o, 32'h0);
    check("rst_flags", {overflow, seq_err}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Row 0, cols 0..7: first word visible right after col 3
    for (int c = 0; c < 8; c++) begin
      pixel(0, c, 8'(c));
      if (c == 2) check("lat_not_yet", wif.word_valid_o, 1'b0);
      if (c == 3) begin
        check("w1_valid", wif.word_valid_o, 1'b1);
        check("w1_data", wif.word_o, 32'h03020100);
        check("w1_be", wif.word_be_o, 4'hF);
        check("w1_addr", wif.word_addr_o, 8'd0);
        check("w1_sof", wif.word_sof_o, 1'b1);
      end
    end
    check("w2_data", wif.word_o, 32'h07060504);
    check("w2_addr", wif.word_addr_o, 8'd1);
    check("w2_sof", wif.word_sof_o, 1'b0);
    idle();

    // Short last word of a 10-pixel row
    for (int c = 0; c < 10; c++) pixel(1, c, 8'(c));
    check("short_be", wif.word_be_o, 4'h3);
    check("short_addr", wif.word_addr_o, 8'd5);
    check("short_data", wif.word_o[15:0], 16'h0908);
    idle();

    // Stale partial is discarded
    pixel(0, 0, 8'hA0);
    pixel(0, 1, 8'hA1);
    pixel(0, 8, 8'hA8);
    check("stale_nopush", wif.word_valid_o, 1'b0);
    check("stale_err", seq_err, 1'b1);
    clr = 1'b1;
    idle();
    clr = 1'b0;
    check("stale_clear", seq_err, 1'b0);
    pixel(0, 9, 8'hA9);
    idle();

    // Overflow: 9 words with ready low, then push+pop while full, then drain
    wif.word_ready_i = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 10; c++) pixel(r, c, 8'($urandom));
    check("ovf_set", overflow, 1'b1);
    clr = 1'b1;
    idle();
    clr = 1'b0;
    for (int c = 0; c < 3; c++) pixel(3, c, 8'($urandom));
    wif.word_ready_i = 1'b1;
    pixel(3, 3, 8'($urandom));
    check("full_pushpop_ovf", overflow, 1'b0);
    wif.word_ready_i = 1'b0;
    idle();
    check("full_depth", 64'(m_q.size()), 64'(DEPTH));
    wif.word_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) idle();

    // Randomized traffic
    rr = 0; cc = 0;
    for (int i = 0; i < 1500; i++) begin
      wif.word_ready_i = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      x = $urandom_range(0, 99);
      if (x < 20) idle();
      else if (x < 23) pixel(H + $urandom_range(0, 3), $urandom_range(0, W + 3), 8'($urandom));
      else if (x < 26) begin
        rr = $urandom_range(0, H - 1);
        cc = $urandom_range(0, W - 1);
        pixel(rr, cc, 8'($urandom));
      end else if (x < 28) pixel(rr, cc, 8'($urandom));
      else begin
        pixel(rr, cc, 8'($urandom));
        cc++;
        if (cc == W) begin
          cc = 0;
          rr = (rr + 1) % H;
        end
      end
    end
    clr = 1'b0;
    wif.word_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) idle();

`ifdef CAMERA_WORD_PACKER_STATS_EN
    check("stat_pushed", words_pushed, m_pushed);
    check("stat_dropped", words_dropped, m_dropped);
`endif

    // Asynchronous reset in the middle of a word
    wif.word_ready_i = 1'b0;
    for (int c = 0; c < 6; c++) pixel(0, c, 8'($urandom));
    pixel(H, 0, 8'h00);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_valid", wif.word_valid_o, 1'b0);
    check("arst_word", {wif.word_o, wif.word_be_o, wif.word_addr_o, wif.word_sof_o}, 45'h0);
    check("arst_flags", {overflow, seq_err}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    wif.word_ready_i = 1'b1;
    idle();
    for (int c = 0; c < 4; c++) pixel(0, c, 8'(8'h10 + c));
    check("post_rst_be", wif.word_be_o, 4'hF);
    check("post_rst_data", wif.word_o, 32'h13121110);
    check("post_rst_err", seq_err, 1'b0);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
